// File: rtl/rle_compressor_if.sv
// Stream interface of the run-length compressor: pixel input side,
// run-word output side and frame status.
interface rle_compressor_if #(
  parameter int IMG_BITS = 16384,
  parameter int CNT_W    = 15
);
  localparam int WORD_W = CNT_W + 1;
  localparam int WC_W   = $clog2(IMG_BITS + 1);

  logic              start;
  logic              pix_valid;
  logic              pix_bit;
  logic              pix_ready;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;
  logic              busy;
  logic              done;
  logic [WC_W-1:0]   word_count;

  modport master (
    output start, pix_valid, pix_bit, word_ready,
    input  pix_ready, word_valid, word_data, busy, done, word_count
  );

  modport slave (
    input  start, pix_valid, pix_bit, word_ready,
    output pix_ready, word_valid, word_data, busy, done, word_count
  );
endinterface

// File: rtl/rle_compressor.sv
// Run-length encoder for a fixed-size 1-bit image stream, emitting
// {run_bit, run_count} words and flushing the last run at end of frame.
module rle_compressor #(
  parameter int IMG_BITS = 16384,
  parameter int CNT_W    = 15
) (
  input logic             clk,
  input logic             rst_n,
  rle_compressor_if.slave bus
);
  localparam int WORD_W = CNT_W + 1;
  localparam int WC_W   = $clog2(IMG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WC_W-1:0]  WC_MAX   = '1;
  localparam logic [WC_W-1:0]  LAST_PIX = WC_W'(IMG_BITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t            state, state_next;
  logic              cur_bit;
  logic [CNT_W-1:0]  cnt;
  logic [WC_W-1:0]   pix_idx;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic [WC_W-1:0]   word_count;
  logic              busy;
  logic              done;

  logic pix_ready, start_ok, pix_take, pix_last, run_close, flush_load, word_take;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A new start is refused during the done cycle, while busy is still high.
  always_comb begin
    pix_ready  = (state == RUN) && !word_valid;
    start_ok   = (state == IDLE) && bus.start && !busy;
    pix_take   = bus.pix_valid && pix_ready;
    pix_last   = (pix_idx == LAST_PIX);
    run_close  = pix_take && (cnt != '0) &&
                 ((bus.pix_bit != cur_bit) || (cnt == CNT_MAX));
    flush_load = (state == FLUSH) && !word_valid;
    word_take  = word_valid && bus.word_ready;
    state_next = state;
    case (state)
      IDLE:    if (start_ok)            state_next = RUN;
      RUN:     if (pix_take && pix_last) state_next = FLUSH;
      FLUSH:   if (flush_load)          state_next = DRAIN;
      DRAIN:   if (word_take)           state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_bit    <= 1'b0;
      cnt        <= '0;
      pix_idx    <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        busy       <= 1'b1;
        word_count <= '0;
        pix_idx    <= '0;
        cnt        <= '0;
      end else if (done) begin
        busy <= 1'b0;
      end
      // Pixels are only taken with the output register empty, so a closing run can load it.
      if (pix_take) begin
        pix_idx <= pix_idx + WC_W'(1);
        if (cnt == '0) begin
          cur_bit <= bus.pix_bit;
          cnt     <= CNT_W'(1);
        end else if (!run_close) begin
          cnt <= cnt + CNT_W'(1);
        end else begin
          word_data  <= {cur_bit, cnt};
          word_valid <= 1'b1;
          cur_bit    <= bus.pix_bit;
          cnt        <= CNT_W'(1);
        end
      end
      if (flush_load) begin
        word_data  <= {cur_bit, cnt};
        word_valid <= 1'b1;
      end
      if (word_take) begin
        word_valid <= 1'b0;
        if (word_count != WC_MAX) word_count <= word_count + WC_W'(1);
        if (state == DRAIN) done <= 1'b1;
      end
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.word_valid = word_valid;
  assign bus.word_data  = word_data;
  assign bus.word_count = word_count;
  assign bus.busy       = busy;
  assign bus.done       = done;
endmodule
